// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared types and constants for the serial board receiver controller.
//   cell_t       : 2-bit intersection code (00 empty, 01 black, 10 white, 11 illegal)
//   ctrl_state_t : sequencing states of board_rx_ctrl
//   board_t      : full 162-bit frame, cell i = bits [2i+1:2i]
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int CELLS     = 81;
    localparam int PKT_LNGTH = 2 * CELLS;
    localparam int IDX_W     = $clog2(CELLS);

    typedef logic [PKT_LNGTH-1:0] board_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        BLACK   = 2'b01,
        WHITE   = 2'b10,
        ILLEGAL = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        PUBLISH,
        RECOVER
    } ctrl_state_t;

    // Extract cell idx from a board; {idx,0} is the bit offset 2*idx.
    function automatic cell_t cell_at(input board_t b, input logic [IDX_W-1:0] idx);
        return cell_t'(b[{idx, 1'b0} +: 2]);
    endfunction

    // 8-bit counter increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_watchdog.sv
// -----------------------------------------------------------------------------
// rx_watchdog
// Stall detector and receiver-reset sequencer.
//   clk_in, rst_in : clock, synchronous active-high reset
//   arm            : controller is waiting for a frame to complete
//   sig            : synchronized serial line; the first low sample starts timing
//   clear          : drop any armed/counting state
//   expired        : one-cycle pulse, TIMEOUT_CYC cycles after the first low sample
//   rx_rst         : reset to the receiver; high during rst_in and for RST_CYC
//                    cycles after expired
//   rst_done       : last cycle of an rx_rst pulse
// -----------------------------------------------------------------------------
module rx_watchdog
    import board_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int RST_CYC     = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic arm,
    input  logic sig,
    input  logic clear,
    output logic expired,
    output logic rx_rst,
    output logic rst_done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam int RC_W  = $clog2(RST_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYC - 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [RC_W-1:0]  rst_cnt;

    // The arming sample holds cnt at 0, so cnt == k after k further cycles.
    assign expired  = arm && running && (cnt == CNT_LAST);
    assign rst_done = rx_rst && (rst_cnt == '0);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear || expired) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (arm) begin
            if (running)
                cnt <= cnt + CNT_W'(1);
            else if (!sig)
                running <= 1'b1;
        end
    end

    // rx_rst comes up with rst_in and drops the first cycle after it; a
    // recovery holds it for RST_CYC cycles by counting rst_cnt down to 0.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_rst  <= 1'b1;
            rst_cnt <= '0;
        end else if (expired) begin
            rx_rst  <= 1'b1;
            rst_cnt <= RST_LAST;
        end else if (rx_rst) begin
            if (rst_cnt == '0)
                rx_rst <= 1'b0;
            else
                rst_cnt <= rst_cnt - RC_W'(1);
        end
    end

endmodule

// File: rtl/board_rx_ctrl.sv
// -----------------------------------------------------------------------------
// board_rx_ctrl
// Sequencing controller for the 162-bit serial board receiver. Waits for a
// frame to complete (rx_ready rising), captures it, scans the 81 cells one per
// cycle for illegal codes and changes, then publishes legal boards over a
// valid/ready handshake. A watchdog recovers the receiver from stalled frames.
//
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   rx_ready         receiver idle flag (low while a frame is armed/being read)
//   rx_data          receiver parallel frame, cell i = rx_data[2i+1:2i]
//   rx_sig           synchronized serial line (watchdog only)
//   rx_rst           reset to the receiver
//   board_out        last published board
//   board_valid      board_out holds an unconsumed board
//   board_ready      consumer accepts the board
//   board_diff       published board differs from the one it replaced
//   err_cnt          saturating count of rejected frames
//   overrun_cnt      saturating count of unconsumed boards overwritten
//   timeout_cnt      saturating count of watchdog recoveries
//   black_cnt        black stones in the published board
//   white_cnt        white stones in the published board
//
// Build option: define BOARD_STATS_EN to enable black_cnt/white_cnt; when
// undefined both are tied to 0.
// -----------------------------------------------------------------------------
module board_rx_ctrl
    import board_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int RST_CYC     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rx_ready,
    input  logic [PKT_LNGTH-1:0] rx_data,
    input  logic                 rx_sig,
    output logic                 rx_rst,
    output logic [PKT_LNGTH-1:0] board_out,
    output logic                 board_valid,
    input  logic                 board_ready,
    output logic                 board_diff,
    output logic [7:0]           err_cnt,
    output logic [7:0]           overrun_cnt,
    output logic [7:0]           timeout_cnt,
    output logic [6:0]           black_cnt,
    output logic [6:0]           white_cnt
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

    ctrl_state_t      state, state_nxt;
    logic             rx_ready_q, rx_ready_qq;
    logic             rx_rise;
    board_t           shadow;
    logic [IDX_W-1:0] idx;
    logic             illegal_flag, diff_flag;
    cell_t            cell_new, cell_old;

    logic load_frame, scan, publish, wd_arm, wd_clear;
    logic wd_expired, wd_done;
    logic transfer;

    // rx_ready goes through two registers; the rise is seen one cycle after
    // the edge that first samples it high.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_ready_q  <= 1'b1;
            rx_ready_qq <= 1'b1;
        end else begin
            rx_ready_q  <= rx_ready;
            rx_ready_qq <= rx_ready_q;
        end
    end

    assign rx_rise  = rx_ready_q && !rx_ready_qq;
    assign transfer = board_valid && board_ready;
    assign cell_new = cell_at(shadow, idx);
    assign cell_old = cell_at(board_out, idx);

    rx_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RST_CYC     (RST_CYC)
    ) u_watchdog (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .arm      (wd_arm),
        .sig      (rx_sig),
        .clear    (wd_clear),
        .expired  (wd_expired),
        .rx_rst   (rx_rst),
        .rst_done (wd_done)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: the default assignment before the case keeps this block purely
    // combinational; a path that leaves state_nxt unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_ready) state_nxt = RECV;
            // A completed frame beats a coincident watchdog expiry.
            RECV:    if (rx_rise)         state_nxt = CHECK;
                     else if (wd_expired) state_nxt = RECOVER;
            CHECK:   if (idx == IDX_LAST) state_nxt = PUBLISH;
            PUBLISH: state_nxt = IDLE;
            RECOVER: if (wd_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: decoded controls ----------------
    always_comb begin
        load_frame = 1'b0;
        scan       = 1'b0;
        publish    = 1'b0;
        wd_arm     = 1'b0;
        wd_clear   = 1'b0;
        case (state)
            IDLE:    wd_clear = 1'b1;
            RECV: begin
                load_frame = rx_rise;
                // Disarming on the rise keeps the watchdog from firing on it.
                wd_arm     = !rx_rise;
            end
            CHECK:   scan    = 1'b1;
            PUBLISH: publish = 1'b1;
            default: ;
        endcase
    end

    // ---------------- capture and scan ----------------
    // NOTE: the shadow frame is an ordinary wide register, not a memory, so it
    // is cleared on reset; an aborted scan never leaves stale data behind.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow       <= '0;
            idx          <= '0;
            illegal_flag <= 1'b0;
            diff_flag    <= 1'b0;
        end else if (load_frame) begin
            shadow       <= rx_data;
            idx          <= '0;
            illegal_flag <= 1'b0;
            diff_flag    <= 1'b0;
        end else if (scan) begin
            if (cell_new == ILLEGAL)  illegal_flag <= 1'b1;
            if (cell_new != cell_old) diff_flag    <= 1'b1;
            if (idx != IDX_LAST)      idx          <= idx + IDX_W'(1);
        end
    end

    // ---------------- publish and handshake ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            board_out   <= '0;
            board_valid <= 1'b0;
            board_diff  <= 1'b0;
            err_cnt     <= '0;
            overrun_cnt <= '0;
        end else if (publish && !illegal_flag) begin
            board_out   <= shadow;
            board_diff  <= diff_flag;
            board_valid <= 1'b1;
            // A same-cycle transfer consumed the old board, so it is no overrun.
            if (board_valid && !board_ready)
                overrun_cnt <= sat_inc8(overrun_cnt);
        end else begin
            if (publish)
                err_cnt <= sat_inc8(err_cnt);
            if (transfer)
                board_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            timeout_cnt <= '0;
        else if (wd_expired)
            timeout_cnt <= sat_inc8(timeout_cnt);
    end

    // ---------------- optional stone statistics ----------------
`ifdef BOARD_STATS_EN
    logic [6:0] black_acc, white_acc;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            black_acc <= '0;
            white_acc <= '0;
            black_cnt <= '0;
            white_cnt <= '0;
        end else if (load_frame) begin
            black_acc <= '0;
            white_acc <= '0;
        end else if (scan) begin
            if (cell_new == BLACK) black_acc <= black_acc + 7'd1;
            if (cell_new == WHITE) white_acc <= white_acc + 7'd1;
        end else if (publish && !illegal_flag) begin
            black_cnt <= black_acc;
            white_cnt <= white_acc;
        end
    end
`else
    assign black_cnt = '0;
    assign white_cnt = '0;
`endif

endmodule

// File: tb/tb_board_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_rx_ctrl
// Self-checking bench for board_rx_ctrl (TIMEOUT_CYC=100, RST_CYC=4).
// A table of frames with hand-computed expected outputs is applied in order,
// followed by hand-written watchdog and mid-scan reset sequences.
// -----------------------------------------------------------------------------
module tb_board_rx_ctrl;
    import board_pkg::*;

    localparam int TIMEOUT_CYC = 100;
    localparam int RST_CYC     = 4;
`ifdef BOARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rx_ready;
    board_t     rx_data;
    logic       rx_sig;
    logic       rx_rst;
    board_t     board_out;
    logic       board_valid;
    logic       board_ready;
    logic       board_diff;
    logic [7:0] err_cnt, overrun_cnt, timeout_cnt;
    logic [6:0] black_cnt, white_cnt;

    board_rx_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RST_CYC     (RST_CYC)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_sig      (rx_sig),
        .rx_rst      (rx_rst),
        .board_out   (board_out),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .board_diff  (board_diff),
        .err_cnt     (err_cnt),
        .overrun_cnt (overrun_cnt),
        .timeout_cnt (timeout_cnt),
        .black_cnt   (black_cnt),
        .white_cnt   (white_cnt)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input board_t act, input board_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic board_t fill(input logic [1:0] code);
        board_t b;
        for (int i = 0; i < CELLS; i++) b[2*i +: 2] = code;
        return b;
    endfunction

    function automatic board_t with_cell(input board_t b, input int i, input logic [1:0] code);
        board_t r;
        r = b;
        r[2*i +: 2] = code;
        return r;
    endfunction

    typedef struct {
        string      name;
        board_t     frame;
        bit         pre_consume;   // pulse board_ready once while idle first
        bit         ready_at_pub;  // board_ready high only in the PUBLISH cycle
        bit         chk_latency;   // board_valid was 0: check the 83-cycle latency
        bit         exp_valid;
        board_t     exp_board;
        bit         exp_diff;
        logic [7:0] exp_err;
        logic [7:0] exp_ovr;
        logic [6:0] exp_blk;
        logic [6:0] exp_wht;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        if (v.pre_consume) begin
            board_ready = 1'b1;
            tick();
            board_ready = 1'b0;
            check({v.name, "_consumed"}, board_t'(board_valid), board_t'(0));
        end
        rx_data  = v.frame;
        rx_ready = 1'b0;
        ticks(3);
        rx_ready = 1'b1;
        // 83 edges: the sampling edge, load edge and 81 scan edges -> PUBLISH.
        ticks(83);
        if (v.chk_latency)
            check({v.name, "_valid_early"}, board_t'(board_valid), board_t'(0));
        if (v.ready_at_pub) board_ready = 1'b1;
        tick();
        board_ready = 1'b0;
        if (v.chk_latency)
            check({v.name, "_valid_at_83"}, board_t'(board_valid), board_t'(1));
        ticks(2);
        check({v.name, "_valid"},   board_t'(board_valid), board_t'(v.exp_valid));
        check({v.name, "_board"},   board_out,             v.exp_board);
        check({v.name, "_diff"},    board_t'(board_diff),  board_t'(v.exp_diff));
        check({v.name, "_err"},     board_t'(err_cnt),     board_t'(v.exp_err));
        check({v.name, "_overrun"}, board_t'(overrun_cnt), board_t'(v.exp_ovr));
        check({v.name, "_black"},   board_t'(black_cnt),   board_t'(STATS ? v.exp_blk : 7'd0));
        check({v.name, "_white"},   board_t'(white_cnt),   board_t'(STATS ? v.exp_wht : 7'd0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        board_t all_b, all_w, empty, bad40, mixed;
        int n, hi;

        all_b = fill(2'b01);
        all_w = fill(2'b10);
        empty = fill(2'b00);
        bad40 = with_cell(all_b, 40, 2'b11);
        mixed = with_cell(with_cell(empty, 0, 2'b01), 80, 2'b10);

        //          name        frame  pre ready lat  valid board  diff err   ovr   blk  wht
        vecs[0] = '{"illegal0", bad40, 0,  0,    0,   0,    empty, 0,   8'd1, 8'd0, 7'd0, 7'd0};
        vecs[1] = '{"black1",   all_b, 0,  0,    1,   1,    all_b, 1,   8'd1, 8'd0, 7'd81, 7'd0};
        vecs[2] = '{"black2",   all_b, 0,  0,    0,   1,    all_b, 0,   8'd1, 8'd1, 7'd81, 7'd0};
        vecs[3] = '{"white_hs", all_w, 0,  1,    0,   1,    all_w, 1,   8'd1, 8'd1, 7'd0, 7'd81};
        vecs[4] = '{"empty",    empty, 1,  0,    0,   1,    empty, 1,   8'd1, 8'd1, 7'd0, 7'd0};
        vecs[5] = '{"mixed",    mixed, 1,  0,    0,   1,    mixed, 1,   8'd1, 8'd1, 7'd1, 7'd1};
        vecs[6] = '{"illegal1", bad40, 0,  0,    0,   1,    mixed, 1,   8'd2, 8'd1, 7'd1, 7'd1};
        vecs[7] = '{"mixed_eq", mixed, 1,  0,    0,   1,    mixed, 0,   8'd2, 8'd1, 7'd1, 7'd1};

        // ---------------- reset ----------------
        rst_in      = 1'b1;
        rx_ready    = 1'b1;
        rx_sig      = 1'b1;
        rx_data     = '0;
        board_ready = 1'b0;
        ticks(3);
        check("rst_rx_rst",  board_t'(rx_rst),      board_t'(1));
        check("rst_valid",   board_t'(board_valid), board_t'(0));
        check("rst_board",   board_out,             board_t'(0));
        check("rst_diff",    board_t'(board_diff),  board_t'(0));
        check("rst_err",     board_t'(err_cnt),     board_t'(0));
        check("rst_overrun", board_t'(overrun_cnt), board_t'(0));
        check("rst_timeout", board_t'(timeout_cnt), board_t'(0));
        rst_in = 1'b0;
        tick();
        check("rst_release_rx_rst", board_t'(rx_rst), board_t'(0));

        // ---------------- frame table ----------------
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // ---------------- watchdog recovery ----------------
        rx_ready = 1'b0;
        ticks(2);
        rx_sig = 1'b0;
        tick();              // first edge sampling rx_sig low
        rx_sig = 1'b1;
        n = 0;
        while (n < 200 && !rx_rst) begin
            tick();
            n++;
        end
        check("wd_delay", board_t'(n), board_t'(100));
        rx_ready = 1'b1;     // the receiver comes back idle after its reset
        hi = rx_rst ? 1 : 0;
        while (hi > 0 && hi < 50 && rx_rst) begin
            tick();
            if (rx_rst) hi++;
        end
        check("wd_rst_len",  board_t'(hi),          board_t'(4));
        check("wd_timeout",  board_t'(timeout_cnt), board_t'(1));
        ticks(90);
        check("wd_idle_valid", board_t'(board_valid), board_t'(1));
        check("wd_idle_board", board_out,             mixed);
        check("wd_idle_err",   board_t'(err_cnt),     board_t'(2));

        // ---------------- reset at scan index 50 ----------------
        rx_data  = all_w;
        rx_ready = 1'b0;
        ticks(3);
        rx_ready = 1'b1;
        ticks(52);           // scan index 50 is under inspection now
        rst_in = 1'b1;
        tick();
        check("midrst_rx_rst",  board_t'(rx_rst),      board_t'(1));
        check("midrst_valid",   board_t'(board_valid), board_t'(0));
        check("midrst_board",   board_out,             board_t'(0));
        check("midrst_diff",    board_t'(board_diff),  board_t'(0));
        check("midrst_err",     board_t'(err_cnt),     board_t'(0));
        check("midrst_overrun", board_t'(overrun_cnt), board_t'(0));
        check("midrst_timeout", board_t'(timeout_cnt), board_t'(0));
        check("midrst_black",   board_t'(black_cnt),   board_t'(0));
        check("midrst_white",   board_t'(white_cnt),   board_t'(0));
        tick();
        rst_in = 1'b0;
        tick();
        check("midrst_release_rx_rst", board_t'(rx_rst), board_t'(0));
        ticks(100);
        check("midrst_no_pub_valid", board_t'(board_valid), board_t'(0));
        check("midrst_no_pub_board", board_out,             board_t'(0));
        check("midrst_no_pub_err",   board_t'(err_cnt),     board_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
